knn_vote: RTL and testbench

KNN_VOTE -- requirements
Module: knn_vote

---
 rtl/knn_vote_pkg.sv | 24 ++
 rtl/knn_match_cnt.sv | 38 +++
 rtl/knn_vote.sv | 116 +++++++++++
 tb/tb_knn_vote.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/knn_vote_pkg.sv
// rtl/knn_vote_pkg.sv - shared types and constants for the k-NN majority vote
package knn_vote_pkg;

  localparam int KNN_DATA_W = 32;
  localparam int KNN_K      = 4;
  localparam int KNN_C      = 8;
  localparam int DATA_INFO  = KNN_DATA_W + KNN_C;

  function automatic int cnt_width(input int k);
    return $clog2(k + 1);
  endfunction

  localparam int CNT_W = cnt_width(KNN_K);

  // A distance of all ones marks an unused neighbour slot.
  localparam logic [KNN_DATA_W-1:0] EMPTY_DIST = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/knn_match_cnt.sv
// rtl/knn_match_cnt.sv - counts valid entries sharing the label of entry idx_i
module knn_match_cnt
  import knn_vote_pkg::*;
#(
  parameter int DATA_W    = KNN_DATA_W,
  parameter int K         = KNN_K,
  parameter int C         = KNN_C,
  parameter int ENTRY_W   = DATA_W + C,
  parameter int IDX_W     = (K > 1) ? $clog2(K) : 1,
  parameter int VOTE_W    = cnt_width(K)
) (
  input  logic [K*ENTRY_W-1:0] list_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic [VOTE_W-1:0]    matches_o,
  output logic                 valid_o,
  output logic [C-1:0]         label_o
);

  logic [C-1:0] lbl [K];
  logic         vld [K];

  for (genvar g = 0; g < K; g++) begin : g_entry
    assign lbl[g] = list_i[(K-g-1)*ENTRY_W +: C];
    assign vld[g] = ~&list_i[(K-g-1)*ENTRY_W + C +: DATA_W];
  end

  always_comb begin
    matches_o = '0;
    valid_o   = vld[idx_i];
    label_o   = lbl[idx_i];
    for (int j = 0; j < K; j++) begin
      if (vld[j] && (lbl[j] == lbl[idx_i])) begin
        matches_o = matches_o + VOTE_W'(1);
      end
    end
  end

endmodule

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - sequential majority vote over a sorted k-nearest-neighbour list
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int DATA_W = KNN_DATA_W,
  parameter int K      = KNN_K,
  parameter int C      = KNN_C,
  parameter int ENTRY_W = DATA_W + C
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [K*ENTRY_W-1:0]     nb_list,
  output logic                     busy,
  output logic                     done,
  output logic [C-1:0]             label_out,
  output logic [$clog2(K+1)-1:0]   votes,
  output logic                     empty
);

  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int VOTE_W = cnt_width(K);

  state_e               state_q;
  logic [K*ENTRY_W-1:0] list_q;
  logic [IDX_W-1:0]     idx_q;
  logic [VOTE_W-1:0]    best_cnt_q, best_cnt_d;
  logic [C-1:0]         best_label_q, best_label_d;
  logic                 busy_q, done_q, empty_q;
  logic [C-1:0]         label_out_q;
  logic [VOTE_W-1:0]    votes_q;

  logic [VOTE_W-1:0]    m_cnt;
  logic                 m_valid;
  logic [C-1:0]         m_label;

  knn_match_cnt #(
    .DATA_W (DATA_W),
    .K      (K),
    .C      (C),
    .ENTRY_W(ENTRY_W),
    .IDX_W  (IDX_W),
    .VOTE_W (VOTE_W)
  ) u_match (
    .list_i   (list_q),
    .idx_i    (idx_q),
    .matches_o(m_cnt),
    .valid_o  (m_valid),
    .label_o  (m_label)
  );

  // Strict greater-than keeps the nearer entry on ties.
  always_comb begin
    best_cnt_d   = best_cnt_q;
    best_label_d = best_label_q;
    if (state_q == ST_SCAN && m_valid && (m_cnt > best_cnt_q)) begin
      best_cnt_d   = m_cnt;
      best_label_d = m_label;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      list_q       <= '0;
      idx_q        <= '0;
      best_cnt_q   <= '0;
      best_label_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      label_out_q  <= '0;
      votes_q      <= '0;
      empty_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            list_q       <= nb_list;
            idx_q        <= '0;
            best_cnt_q   <= '0;
            best_label_q <= '0;
            busy_q       <= 1'b1;
            state_q      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          best_cnt_q   <= best_cnt_d;
          best_label_q <= best_label_d;
          if (idx_q == IDX_W'(K - 1)) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            label_out_q <= best_label_d;
            votes_q     <= best_cnt_d;
            // Any valid entry matches itself, so a zero count means no valid entry.
            empty_q     <= (best_cnt_d == '0);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign label_out = label_out_q;
  assign votes     = votes_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_knn_vote.sv
// tb/tb_knn_vote.sv - scoreboard bench for knn_vote with directed vectors
module tb_knn_vote;
  import knn_vote_pkg::*;

  localparam int K  = 4;
  localparam int DI = 40;

  typedef struct packed {
    logic [7:0] lbl;
    logic [2:0] v;
    logic       e;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic [K*DI-1:0] nb_list;
  logic            busy, done, empty;
  logic [7:0]      label_out;
  logic [2:0]      votes;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  knn_vote dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .nb_list  (nb_list),
    .busy     (busy),
    .done     (done),
    .label_out(label_out),
    .votes    (votes),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic logic [K*DI-1:0] mk(input logic [7:0] l0, input logic [7:0] l1,
                                         input logic [7:0] l2, input logic [7:0] l3,
                                         input logic [3:0] inv);
    logic [K*DI-1:0] r;
    logic [7:0]      l [K];
    logic [31:0]     d;
    l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
    r = '0;
    for (int i = 0; i < K; i++) begin
      d = inv[i] ? EMPTY_DIST : 32'(10 * (i + 1));
      r[(K-i)*DI-1 -: DI] = {d, l[i]};
    end
    return r;
  endfunction

  function automatic exp_t ex(input logic [7:0] lb, input logic [2:0] v, input logic e);
    exp_t t;
    t.lbl = lb; t.v = v; t.e = e;
    return t;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("label_out", int'(label_out), int'(mon_e.lbl));
        chk("votes", int'(votes), int'(mon_e.v));
        chk("empty", int'(empty), int'(mon_e.e));
      end
    end
  end

  task automatic run(input logic [K*DI-1:0] lst, input exp_t e, input string nm);
    int n;
    bit seen;
    nb_list = lst;
    exp_q.push_back(e);
    start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        chk({nm, "_busy"}, int'(busy), 1);
      end
      if (done) seen = 1'b1;
    end
    chk({nm, "_latency"}, n, K + 1);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, int'(done), 0);
    chk({nm, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int ndone;
    int d_at [3];
    int low_cnt;
    rst = 1'b0;
    start = 1'b0;
    nb_list = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_label", int'(label_out), 0);
    chk("rst_votes", int'(votes), 0);
    chk("rst_empty", int'(empty), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run(mk(8'd3, 8'd3, 8'd5, 8'd7, 4'b0000), ex(8'd3, 3'd2, 1'b0), "majority");
    run(mk(8'd5, 8'd3, 8'd3, 8'd5, 4'b0000), ex(8'd5, 3'd2, 1'b0), "tie_sym");
    run(mk(8'd5, 8'd3, 8'd5, 8'd3, 4'b0000), ex(8'd5, 3'd2, 1'b0), "tie_alt");
    run(mk(8'd9, 8'd1, 8'd2, 8'd4, 4'b0000), ex(8'd9, 3'd1, 1'b0), "all_distinct");
    run(mk(8'd6, 8'd2, 8'd6, 8'd6, 4'b1100), ex(8'd6, 3'd1, 1'b0), "partial_invalid");
    run(mk(8'd6, 8'd2, 8'd6, 8'd6, 4'b1111), ex(8'd0, 3'd0, 1'b1), "all_invalid");

    // Restart while busy and list change after capture.
    nb_list = mk(8'd3, 8'd3, 8'd5, 8'd7, 4'b0000);
    exp_q.push_back(ex(8'd3, 3'd2, 1'b0));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb_list = mk(8'd1, 8'd2, 8'd2, 8'd2, 4'b0000);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("restart_single_done", ndone, 1);

    // Reset in the second scan cycle aborts without a done pulse.
    nb_list = mk(8'd4, 8'd4, 8'd4, 8'd1, 4'b0000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_label", int'(label_out), 0);
    chk("abort_votes", int'(votes), 0);
    chk("abort_empty", int'(empty), 0);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run(mk(8'd5, 8'd3, 8'd3, 8'd5, 4'b0000), ex(8'd5, 3'd2, 1'b0), "after_abort");

    // Start held high across three back-to-back runs.
    nb_list = mk(8'd9, 8'd1, 8'd2, 8'd4, 4'b0000);
    for (int i = 0; i < 3; i++) exp_q.push_back(ex(8'd9, 3'd1, 1'b0));
    ndone = 0;
    low_cnt = 0;
    start = 1'b1;
    for (int i = 0; i < 40 && ndone < 3; i++) begin
      @(posedge clk); #1;
      if (ndone >= 1 && !busy) low_cnt++;
      if (done) begin
        d_at[ndone] = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    chk("held_done_count", ndone, 3);
    if (ndone == 3) begin
      chk("held_gap1", d_at[1] - d_at[0], K + 2);
      chk("held_gap2", d_at[2] - d_at[1], K + 2);
    end
    chk("held_busy_low", low_cnt, 2);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
